seq_loop_ctrl: RTL and testbench

SEQ_LOOP_CTRL -- requirements
Module: seq_loop_ctrl

---
 rtl/seq_loop_ctrl.sv | 89 ++++++++
 tb/tb_seq_loop_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_loop_ctrl.sv
// seq_loop_ctrl: counted-loop sequencer with start/body/done handshake.
// Define SEQ_LOOP_QUIT_EN to add the loop_quit early-exit input.
module seq_loop_ctrl #(
  parameter int FSM_WIDTH = 3,
  parameter int TRIP_W    = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_start,
  input  logic [TRIP_W-1:0]    trip_count,
  input  logic                 body_done,
`ifdef SEQ_LOOP_QUIT_EN
  input  logic                 loop_quit,
`endif
  output logic                 ap_idle,
  output logic                 ap_ready,
  output logic                 ap_done,
  output logic                 body_start,
  output logic [TRIP_W-1:0]    iter_idx,
  output logic [FSM_WIDTH-1:0] cur_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PRE        = 3'd1,
    S_ITER_START = 3'd2,
    S_ITER_WAIT  = 3'd3,
    S_ITER_END   = 3'd4,
    S_POST       = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  state_t            r_state;
  logic [TRIP_W-1:0] r_trip;
  logic [TRIP_W-1:0] r_iter;
  logic              w_last;

`ifdef SEQ_LOOP_QUIT_EN
  assign w_last = (r_iter == r_trip - TRIP_W'(1)) | loop_quit;
`else
  assign w_last = (r_iter == r_trip - TRIP_W'(1));
`endif

  // Loop sequencer: latches the trip count, steps iterations, exits.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= S_IDLE;
      r_trip  <= '0;
      r_iter  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_trip  <= trip_count;
            r_iter  <= '0;
            r_state <= S_PRE;
          end
        end
        S_PRE: begin
          if (r_trip == '0) r_state <= S_POST;
          else              r_state <= S_ITER_START;
        end
        S_ITER_START: r_state <= S_ITER_WAIT;
        S_ITER_WAIT: begin
          if (body_done) r_state <= S_ITER_END;
        end
        S_ITER_END: begin
          if (w_last) begin
            r_state <= S_POST;
          end else begin
            r_iter  <= r_iter + TRIP_W'(1);
            r_state <= S_ITER_START;
          end
        end
        S_POST:  r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ap_idle    = (r_state == S_IDLE);
  assign ap_ready   = (r_state == S_PRE);
  assign ap_done    = (r_state == S_DONE);
  assign body_start = (r_state == S_ITER_START);
  assign iter_idx   = r_iter;
  assign cur_state  = FSM_WIDTH'(r_state);

endmodule

// File: tb/tb_seq_loop_ctrl.sv
// tb_seq_loop_ctrl: directed vector table plus multi-cycle sequences.
// Define SEQ_LOOP_QUIT_EN to also exercise the early-exit path.
module tb_seq_loop_ctrl;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic [15:0] trip_count;
  logic        body_done;
  logic        loop_quit;
  logic        ap_idle;
  logic        ap_ready;
  logic        ap_done;
  logic        body_start;
  logic [15:0] iter_idx;
  logic [2:0]  cur_state;

  int checks = 0;
  int errors = 0;

  seq_loop_ctrl #(
    .FSM_WIDTH (3),
    .TRIP_W    (16)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .ap_start   (ap_start),
    .trip_count (trip_count),
    .body_done  (body_done),
`ifdef SEQ_LOOP_QUIT_EN
    .loop_quit  (loop_quit),
`endif
    .ap_idle    (ap_idle),
    .ap_ready   (ap_ready),
    .ap_done    (ap_done),
    .body_start (body_start),
    .iter_idx   (iter_idx),
    .cur_state  (cur_state)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic        start;
    logic [15:0] trip;
    logic        bd;
    logic [2:0]  st;
    logic [3:0]  fl;
    logic [15:0] it;
  } vec_t;

  vec_t tbl [16];

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [22:0] snap();
    return {cur_state, ap_idle, ap_ready, ap_done, body_start, iter_idx};
  endfunction

  initial begin
    int nbs;
    int nd;
    int cnt;
    int lat;
    int since;
    int found;
    int post_it;
    logic [15:0] ia [3];

    // flags are {idle, ready, done, body_start}
    tbl[0]  = '{1'b0, 16'd2, 1'b0, 3'd0, 4'b1000, 16'd0};
    tbl[1]  = '{1'b1, 16'd2, 1'b1, 3'd1, 4'b0100, 16'd0};
    tbl[2]  = '{1'b0, 16'd9, 1'b1, 3'd2, 4'b0001, 16'd0};
    tbl[3]  = '{1'b0, 16'd9, 1'b1, 3'd3, 4'b0000, 16'd0};
    tbl[4]  = '{1'b0, 16'd9, 1'b0, 3'd3, 4'b0000, 16'd0};
    tbl[5]  = '{1'b0, 16'd9, 1'b1, 3'd4, 4'b0000, 16'd0};
    tbl[6]  = '{1'b0, 16'd9, 1'b0, 3'd2, 4'b0001, 16'd1};
    tbl[7]  = '{1'b0, 16'd9, 1'b0, 3'd3, 4'b0000, 16'd1};
    tbl[8]  = '{1'b0, 16'd9, 1'b1, 3'd4, 4'b0000, 16'd1};
    tbl[9]  = '{1'b0, 16'd9, 1'b1, 3'd5, 4'b0000, 16'd1};
    tbl[10] = '{1'b0, 16'd9, 1'b1, 3'd6, 4'b0010, 16'd1};
    tbl[11] = '{1'b0, 16'd9, 1'b0, 3'd0, 4'b1000, 16'd1};
    tbl[12] = '{1'b1, 16'd0, 1'b0, 3'd1, 4'b0100, 16'd0};
    tbl[13] = '{1'b0, 16'd0, 1'b1, 3'd5, 4'b0000, 16'd0};
    tbl[14] = '{1'b0, 16'd0, 1'b0, 3'd6, 4'b0010, 16'd0};
    tbl[15] = '{1'b0, 16'd0, 1'b0, 3'd0, 4'b1000, 16'd0};

    ap_rst_n   = 1'b0;
    ap_start   = 1'b0;
    trip_count = 16'd0;
    body_done  = 1'b0;
    loop_quit  = 1'b0;

    #12;
    chk("reset_out", 32'(snap()), 32'({3'd0, 4'b1000, 16'd0}));
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // directed table: two-trip run with body_done noise, then zero trip
    for (int i = 0; i < 16; i++) begin
      ap_start   = tbl[i].start;
      trip_count = tbl[i].trip;
      body_done  = tbl[i].bd;
      tick();
      chk($sformatf("vec%0d", i), 32'(snap()),
          32'({tbl[i].st, tbl[i].fl, tbl[i].it}));
    end

    // trip 3, body_done two cycles after each body_start
    trip_count = 16'd3;
    body_done  = 1'b0;
    ap_start   = 1'b1;
    tick();
    ap_start = 1'b0;
    nbs = 0;
    nd  = 0;
    cnt = 99;
    for (int c = 0; c < 100 && nd == 0; c++) begin
      if (body_start) begin
        if (nbs < 3) ia[nbs] = iter_idx;
        nbs++;
        cnt = 0;
      end else begin
        cnt++;
      end
      if (ap_done) nd++;
      body_done = (cnt == 2);
      if (nd == 0) tick();
    end
    chk("A_done", 32'(nd), 32'd1);
    chk("A_nbs", 32'(nbs), 32'd3);
    chk("A_idx0", 32'(ia[0]), 32'd0);
    chk("A_idx1", 32'(ia[1]), 32'd1);
    chk("A_idx2", 32'(ia[2]), 32'd2);
    body_done = 1'b0;
    nd = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ap_done) nd++;
    end
    chk("A_nodone", 32'(nd), 32'd0);
    chk("A_idle", 32'(ap_idle), 32'd1);

    // zero-latency body, trip 4: start edge to done is 3+3*4 edges
    trip_count = 16'd4;
    body_done  = 1'b1;
    ap_start   = 1'b1;
    tick();
    ap_start = 1'b0;
    lat = 1;
    while (!ap_done && lat < 100) begin
      tick();
      lat++;
    end
    chk("lat_n4", 32'(lat), 32'd15);
    body_done = 1'b0;
    tick();

    // reset during ITER_WAIT of iteration 1
    trip_count = 16'd3;
    ap_start   = 1'b1;
    tick();
    ap_start = 1'b0;
    found = 0;
    for (int c = 0; c < 50; c++) begin
      if (cur_state == 3'd3 && iter_idx == 16'd1) begin
        found = 1;
        break;
      end
      body_done = (cur_state == 3'd3 && iter_idx == 16'd0);
      tick();
    end
    chk("B_reach", 32'(found), 32'd1);
    body_done = 1'b0;
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("B_abort", 32'(snap()), 32'({3'd0, 4'b1000, 16'd0}));
    tick();
    chk("B_nodone", 32'(ap_done), 32'd0);
    @(negedge ap_clk);
    ap_rst_n   = 1'b1;
    trip_count = 16'd1;
    body_done  = 1'b1;
    ap_start   = 1'b1;
    tick();
    ap_start = 1'b0;
    lat = 1;
    while (!ap_done && lat < 100) begin
      tick();
      lat++;
    end
    chk("B_rerun_lat", 32'(lat), 32'd6);
    tick();

    // start held high, trip 1: exactly one IDLE cycle between runs
    trip_count = 16'd1;
    body_done  = 1'b1;
    ap_start   = 1'b1;
    nd    = 0;
    since = -1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (since >= 0) since++;
      if (since == 1)
        chk("C_idle", 32'({ap_idle, cur_state}), 32'({1'b1, 3'd0}));
      if (since == 2)
        chk("C_pre", 32'(cur_state), 32'd1);
      if (ap_done) begin
        nd++;
        since = 0;
      end
    end
    chk("C_runs", 32'(nd >= 6), 32'd1);
    ap_start  = 1'b0;
    body_done = 1'b0;
    for (int c = 0; c < 10 && !ap_idle; c++) tick();
    tick();
    chk("C_settle", 32'(ap_idle), 32'd1);

`ifdef SEQ_LOOP_QUIT_EN
    // early exit at iteration 4 of a 10-trip run
    trip_count = 16'd10;
    body_done  = 1'b1;
    ap_start   = 1'b1;
    tick();
    ap_start = 1'b0;
    nbs     = 0;
    nd      = 0;
    post_it = -1;
    for (int c = 0; c < 200 && nd == 0; c++) begin
      if (body_start) nbs++;
      if (cur_state == 3'd5 && post_it < 0) post_it = int'(iter_idx);
      if (ap_done) nd++;
      loop_quit = (cur_state == 3'd4 && iter_idx == 16'd4);
      if (nd == 0) tick();
    end
    loop_quit = 1'b0;
    body_done = 1'b0;
    chk("D_done", 32'(nd), 32'd1);
    chk("D_nbs", 32'(nbs), 32'd5);
    chk("D_post_idx", 32'(post_it), 32'd4);
    chk("D_idx_hold", 32'(iter_idx), 32'd4);
`else
    post_it = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
